// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, 3-point majority voting per bit,
// optional even/odd parity, single stop bit, one-cycle result pulses.
`timescale 1ns/1ps

module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int unsigned PS_W  = 6;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state;
  logic [PS_W-1:0]         ps_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [PS_W-1:0]         edge_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [1:0]              samp;
  logic                    bit_val;
  logic                    par_flag;
  logic [DATA_WIDTH-1:0]   shift_reg;

  logic [PS_W-1:0]         ps_sel;
  logic [PS_W-1:0]         half;
  logic [PS_W-1:0]         samp_lo;
  logic [PS_W-1:0]         samp_hi;
  logic [PS_W-1:0]         last_edge;
  logic                    vote;

  // Unsupported oversampling ratios fall back to 8
  assign ps_sel = (PRESCALE == PS_W'(16)) ? PS_W'(16) :
                  (PRESCALE == PS_W'(32)) ? PS_W'(32) : PS_W'(8);

  // Sample points centred on the middle of the bit, and the last edge of a bit
  assign half      = ps_q >> 1;
  assign samp_lo   = half - PS_W'(1);
  assign samp_hi   = half + PS_W'(1);
  assign last_edge = ps_q - PS_W'(1);

  // Majority of the two stored samples and the live third sample
  assign vote = (samp[0] & samp[1]) | (samp[0] & RX_IN) | (samp[1] & RX_IN);

  // Receiver FSM with counters, sampling, shift register and result pulses
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      ps_q       <= PS_W'(8);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      samp       <= '0;
      bit_val    <= 1'b0;
      par_flag   <= 1'b0;
      shift_reg  <= '0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;

      if (state != IDLE) begin
        if (edge_cnt == samp_lo) samp[0] <= RX_IN;
        if (edge_cnt == half)    samp[1] <= RX_IN;
        if (edge_cnt == samp_hi) bit_val <= vote;
        edge_cnt <= (edge_cnt == last_edge) ? '0 : edge_cnt + PS_W'(1);
      end

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state     <= START;
            edge_cnt  <= PS_W'(1);
            bit_cnt   <= '0;
            ps_q      <= ps_sel;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_flag  <= 1'b0;
          end
        end

        START: begin
          if (edge_cnt == last_edge) state <= bit_val ? IDLE : DATA;
        end

        DATA: begin
          if (edge_cnt == samp_hi) shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
          if (edge_cnt == last_edge) begin
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        PARITY: begin
          // Mismatch when the received bit differs from the expected even/odd parity
          if (edge_cnt == samp_hi) par_flag <= vote ^ (^shift_reg) ^ par_typ_q;
          if (edge_cnt == last_edge) state <= STOP;
        end

        STOP: begin
          if (edge_cnt == last_edge) begin
            state      <= IDLE;
            Data_Valid <= bit_val & ~par_flag;
            Par_Err    <= par_flag;
            Stp_Err    <= ~bit_val;
            if (bit_val && !par_flag) P_DATA <= shift_reg;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a frame-level reference model.
`timescale 1ns/1ps

module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;

  typedef struct {
    int         cyc;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] pd;
  } rec_t;

  rec_t       mon_q[$];
  rec_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_pdata = 8'h00;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every cycle that carries a result pulse
  always @(negedge CLK) begin
    if (Data_Valid || Par_Err || Stp_Err) begin
      rec_t r;
      r.cyc = cyc;
      r.dv  = Data_Valid;
      r.pe  = Par_Err;
      r.se  = Stp_Err;
      r.pd  = P_DATA;
      mon_q.push_back(r);
    end
  end

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // Drive one frame starting at the current negedge; model its expected outcome
  task automatic send_frame(input logic [7:0] d, input logic [5:0] ps, input bit pe,
                            input bit pt, input bit flip_par, input bit bad_stop,
                            input int glitch_bit, input bit scramble);
    int   eff;
    int   ones;
    bit   par_bit;
    bit   par_err;
    bit   frame[$];
    rec_t e;
    eff     = (ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
    ones    = $countones(d);
    par_bit = (pt ? ((ones % 2) == 0) : ((ones % 2) == 1)) ^ flip_par;
    par_err = pe && (((ones + int'(par_bit)) % 2) != (pt ? 1 : 0));
    e.cyc = cyc + (8 + 2 + (pe ? 1 : 0)) * eff;
    e.dv  = !par_err && !bad_stop;
    e.pe  = par_err;
    e.se  = bad_stop;
    if (e.dv) exp_pdata = d;
    e.pd  = exp_pdata;
    exp_q.push_back(e);

    frame.push_back(1'b0);
    for (int i = 0; i < 8; i++) frame.push_back(d[i]);
    if (pe) frame.push_back(par_bit);
    frame.push_back(!bad_stop);

    PRESCALE = ps;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    for (int b = 0; b < frame.size(); b++) begin
      RX_IN = frame[b];
      if (b == 1 && scramble) begin
        PRESCALE = 6'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
      end
      for (int k = 0; k < eff; k++) begin
        if (glitch_bit >= 0 && b == glitch_bit + 1 && k == eff / 2) RX_IN = ~frame[b];
        if (glitch_bit >= 0 && b == glitch_bit + 1 && k == eff / 2 + 1) RX_IN = frame[b];
        @(negedge CLK);
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    RX_IN = 1'b0;
    wait_neg(3);
    checks++;
    if ({P_DATA, Data_Valid, Par_Err, Stp_Err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got pd=%02h dv=%0b pe=%0b se=%0b exp all 0",
               P_DATA, Data_Valid, Par_Err, Stp_Err);
    end
    RX_IN = 1'b1;
    wait_neg(1);
    RST = 1'b1;
    wait_neg(20);
    checks++;
    if (mon_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_idle_pulses got %0d exp 0", mon_q.size());
    end
    mon_q.delete();
  endtask

  task automatic test_basic();
    rec_t g, e;
    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    wait_neg(4);
    checks++;
    if (mon_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      g = mon_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if ({g.cyc, g.dv, g.pe, g.se, g.pd} !== {e.cyc, e.dv, e.pe, e.se, e.pd}) begin
        errors++;
        $display("FAIL basic_frame got cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h exp cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h",
                 g.cyc, g.dv, g.pe, g.se, g.pd, e.cyc, e.dv, e.pe, e.se, e.pd);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity();
    rec_t g, e;
    send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    wait_neg(3);
    send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    wait_neg(3);
    send_frame(8'h07, 6'd16, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    wait_neg(4);
    checks++;
    if (mon_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL parity_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      g = mon_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if ({g.cyc, g.dv, g.pe, g.se, g.pd} !== {e.cyc, e.dv, e.pe, e.se, e.pd}) begin
        errors++;
        $display("FAIL parity_frame got cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h exp cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h",
                 g.cyc, g.dv, g.pe, g.se, g.pd, e.cyc, e.dv, e.pe, e.se, e.pd);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_stop_err();
    rec_t g, e;
    send_frame(8'h81, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    wait_neg(4);
    checks++;
    if (mon_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL stop_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      g = mon_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if ({g.cyc, g.dv, g.pe, g.se, g.pd} !== {e.cyc, e.dv, e.pe, e.se, e.pd}) begin
        errors++;
        $display("FAIL stop_frame got cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h exp cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h",
                 g.cyc, g.dv, g.pe, g.se, g.pd, e.cyc, e.dv, e.pe, e.se, e.pd);
      end
    end
    checks++;
    if (P_DATA !== exp_pdata) begin
      errors++;
      $display("FAIL stop_pdata_hold got %02h exp %02h", P_DATA, exp_pdata);
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_start_glitch();
    rec_t g, e;
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    RX_IN = 1'b0;
    wait_neg(3);
    RX_IN = 1'b1;
    wait_neg(16);
    send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    wait_neg(4);
    checks++;
    if (mon_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL glitch_start_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      g = mon_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if ({g.cyc, g.dv, g.pe, g.se, g.pd} !== {e.cyc, e.dv, e.pe, e.se, e.pd}) begin
        errors++;
        $display("FAIL glitch_start_frame got cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h exp cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h",
                 g.cyc, g.dv, g.pe, g.se, g.pd, e.cyc, e.dv, e.pe, e.se, e.pd);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    rec_t g, e;
    int   pc[$];
    send_frame(8'h12, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    send_frame(8'h34, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    wait_neg(4);
    checks++;
    if (mon_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      g = mon_q.pop_front(); e = exp_q.pop_front();
      pc.push_back(g.cyc);
      checks++;
      if ({g.cyc, g.dv, g.pe, g.se, g.pd} !== {e.cyc, e.dv, e.pe, e.se, e.pd}) begin
        errors++;
        $display("FAIL b2b_frame got cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h exp cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h",
                 g.cyc, g.dv, g.pe, g.se, g.pd, e.cyc, e.dv, e.pe, e.se, e.pd);
      end
    end
    if (pc.size() == 2) begin
      checks++;
      if (pc[1] - pc[0] !== 80) begin
        errors++;
        $display("FAIL b2b_spacing got %0d exp 80", pc[1] - pc[0]);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    rec_t       g, e;
    logic [7:0] d;
    d = 8'hAB;
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    RX_IN = 1'b0;
    wait_neg(8);
    for (int i = 0; i < 4; i++) begin
      RX_IN = d[i];
      wait_neg(8);
    end
    RX_IN = d[4];
    wait_neg(3);
    RST = 1'b0;
    wait_neg(1);
    checks++;
    if ({P_DATA, Data_Valid, Par_Err, Stp_Err} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got pd=%02h dv=%0b pe=%0b se=%0b exp all 0",
               P_DATA, Data_Valid, Par_Err, Stp_Err);
    end
    exp_pdata = 8'h00;
    RX_IN = 1'b1;
    wait_neg(2);
    RST = 1'b1;
    wait_neg(20);
    send_frame(8'hF0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    wait_neg(4);
    checks++;
    if (mon_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL mid_reset_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      g = mon_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if ({g.cyc, g.dv, g.pe, g.se, g.pd} !== {e.cyc, e.dv, e.pe, e.se, e.pd}) begin
        errors++;
        $display("FAIL mid_reset_frame got cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h exp cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h",
                 g.cyc, g.dv, g.pe, g.se, g.pd, e.cyc, e.dv, e.pe, e.se, e.pd);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    rec_t       g, e;
    logic [5:0] ps_tab[10];
    ps_tab = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd16, 6'd32, 6'd5, 6'd12, 6'd63, 6'd0};
    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom), ps_tab[$urandom_range(0, 9)], 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                 ($urandom_range(0, 1) == 1));
      wait_neg($urandom_range(0, 3));
    end
    wait_neg(4);
    checks++;
    if (mon_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_count got %0d exp %0d", mon_q.size(), exp_q.size());
    end
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      g = mon_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if ({g.cyc, g.dv, g.pe, g.se, g.pd} !== {e.cyc, e.dv, e.pe, e.se, e.pd}) begin
        errors++;
        $display("FAIL random_frame got cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h exp cyc=%0d dv=%0b pe=%0b se=%0b pd=%02h",
                 g.cyc, g.dv, g.pe, g.se, g.pd, e.cyc, e.dv, e.pe, e.se, e.pd);
      end
    end
    mon_q.delete(); exp_q.delete();
  endtask

  initial begin
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_start_glitch();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-low.
REQ-004 RX_IN  input  1  serial line, idle high, already synchronous to CLK.
REQ-005 PRESCALE  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 P_DATA  output  DATA_WIDTH  last received data word, LSB received first.
REQ-009 Data_Valid  output  1  one-cycle pulse, frame received without error.
REQ-010 Par_Err  output  1  one-cycle pulse, parity mismatch in the frame just ended.
REQ-011 Stp_Err  output  1  one-cycle pulse, stop bit sampled as 0.

Function
REQ-012 Frame format: start(0), DATA_WIDTH data bits LSB first, optional parity, one stop(1); each bit lasts PRESCALE CLK cycles.
REQ-013 PRESCALE, PAR_EN and PAR_TYP are latched at start detection and held for the whole frame; PRESCALE values outside {8,16,32} behave as 8.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-015 IDLE: a cycle with RX_IN=0 is edge 0 of the start bit; go to START, edge counter = 1 next cycle.
REQ-016 Edge counter counts 0..PRESCALE-1 within each bit and wraps to 0 at each bit boundary; bit counter counts data bits 0..DATA_WIDTH-1.
REQ-017 Each bit value is the majority vote of RX_IN at edges PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1.
REQ-018 START: if the voted start bit is 1 (glitch), return to IDLE at the bit end with no output pulse; otherwise go to DATA.
REQ-019 DATA: shift voted bits into a shift register LSB first; after bit DATA_WIDTH-1 go to PARITY if PAR_EN=1, else to STOP.
REQ-020 PARITY: voted bit compared against XOR of received data (XNOR for odd); store the mismatch flag; then go to STOP.
REQ-021 STOP: at edge PRESCALE-1 return to IDLE; next cycle exactly one of {Data_Valid, or any combination of Par_Err/Stp_Err} is high for one cycle.
REQ-022 Data_Valid latency: pulse begins (DATA_WIDTH+2+PAR_EN)*PRESCALE cycles after the cycle in which the start edge was seen in IDLE.
REQ-023 P_DATA updates only on a Data_Valid frame and otherwise holds its value; an errored frame does not change P_DATA.
REQ-024 Back-to-back frames: IDLE may detect a new start in the same cycle as the pulse of the preceding frame; no dead cycle required.
REQ-025 Input changes on PRESCALE/PAR_EN/PAR_TYP mid-frame have no effect until the next start detection.

Reset
REQ-026 RST=0 at a rising edge: state IDLE, counters 0, shift register 0, P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0.
REQ-027 Reset mid-frame aborts the frame with no pulse; after RST=1 the receiver waits for RX_IN low in IDLE (a line already low is treated as a new start).

Verification
REQ-028 PRESCALE=8, PAR_EN=0, send 0xA5 -> Data_Valid high one cycle at 80 cycles after start edge, P_DATA=0xA5, no errors.
REQ-029 PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> Data_Valid at 176 cycles, P_DATA=0x3C; repeat with parity 1 -> Par_Err pulse, no Data_Valid, P_DATA stays 0x3C.
REQ-030 PRESCALE=32, send 0x81 with stop bit 0 -> Stp_Err pulse, no Data_Valid, P_DATA unchanged.
REQ-031 RX_IN low for 3 cycles then high (PRESCALE=8) -> start rejected, no pulses, next valid frame 0x55 received correctly.
REQ-032 Single-cycle glitch at sample edge PRESCALE/2 of a data bit -> majority vote keeps correct value; back-to-back frames 0x12, 0x34 -> two Data_Valid pulses exactly 80 cycles apart (PRESCALE=8).
REQ-033 RST=0 during data bit 4 of a frame -> all outputs 0 next cycle, no pulse; frame 0xF0 sent after release received correctly.
